// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu_arbiter
// Description : Round-robin arbiter/sequencer sharing one ALU among NREQ
//               requesters, with 1/2-beat result collection and timeout abort.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 15
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [NREQ-1:0]      REQ_VLD,
    output logic [NREQ-1:0]      REQ_RDY,
    input  logic [4*NREQ-1:0]    REQ_OP,
    input  logic [2*NREQ-1:0]    REQ_MOVI,
    input  logic [32*NREQ-1:0]   REQ_A,
    input  logic [32*NREQ-1:0]   REQ_B,
    input  logic [32*NREQ-1:0]   REQ_MEM,
    input  logic [32*NREQ-1:0]   REQ_IMM,
    output logic                 ALU_ACT,
    output logic [3:0]           ALU_OP,
    output logic [1:0]           ALU_MOVI,
    output logic [31:0]          ALU_A,
    output logic [31:0]          ALU_B,
    output logic [31:0]          ALU_MEM,
    output logic [31:0]          ALU_IMM,
    input  logic                 ALU_RDY,
    input  logic                 ALU_VLD,
    input  logic [31:0]          ALU_DATA,
    output logic [NREQ-1:0]      RSP_VLD,
    output logic [63:0]          RSP_DATA,
    output logic                 RSP_ERR,
    output logic                 BUSY
);

    localparam int         PW       = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int         CW       = $clog2(TIMEOUT + 1);
    localparam logic [3:0] c_op_mul = 4'b0010;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE   = 3'd1,
        S_BEAT_LO = 3'd2,
        S_BEAT_HI = 3'd3,
        S_RESP    = 3'd4
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [PW-1:0]   r_ptr;
    logic [PW-1:0]   r_owner;
    logic [CW-1:0]   r_cnt;
    logic [31:0]     r_lo;
    logic [31:0]     r_hi;
    logic            r_err;
    logic            w_gnt_found;
    logic [PW-1:0]   w_gnt_idx;
    logic [PW-1:0]   w_ptr_nxt;
    logic            w_timeout;

    // First pending requester at or after the pointer, wrapping modulo NREQ.
    always_comb begin
        w_gnt_found = 1'b0;
        w_gnt_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!w_gnt_found && REQ_VLD[(int'(r_ptr) + k) % NREQ]) begin
                w_gnt_found = 1'b1;
                w_gnt_idx   = PW'((int'(r_ptr) + k) % NREQ);
            end
        end
    end

    assign w_ptr_nxt = (w_gnt_idx == PW'(NREQ - 1)) ? '0 : w_gnt_idx + 1'b1;
    assign w_timeout = (r_cnt == CW'(TIMEOUT - 1));

    always_comb begin
        w_state_nxt = r_state;
        REQ_RDY     = '0;
        ALU_ACT     = 1'b0;
        RSP_VLD     = '0;
        case (r_state)
            S_IDLE: begin
                if (w_gnt_found) begin
                    REQ_RDY[w_gnt_idx] = 1'b1;
                    w_state_nxt        = S_ISSUE;
                end
            end
            S_ISSUE: begin
                ALU_ACT = ALU_RDY;
                if (ALU_RDY) w_state_nxt = S_BEAT_LO;
            end
            S_BEAT_LO: begin
                if (ALU_VLD)        w_state_nxt = (ALU_OP == c_op_mul) ? S_BEAT_HI : S_RESP;
                else if (w_timeout) w_state_nxt = S_RESP;
            end
            S_BEAT_HI: begin
                if (ALU_VLD || w_timeout) w_state_nxt = S_RESP;
            end
            S_RESP: begin
                RSP_VLD[r_owner] = 1'b1;
                w_state_nxt      = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state  <= S_IDLE;
            r_ptr    <= '0;
            r_owner  <= '0;
            r_cnt    <= '0;
            r_lo     <= '0;
            r_hi     <= '0;
            r_err    <= 1'b0;
            ALU_OP   <= '0;
            ALU_MOVI <= '0;
            ALU_A    <= '0;
            ALU_B    <= '0;
            ALU_MEM  <= '0;
            ALU_IMM  <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                S_IDLE: begin
                    if (w_gnt_found) begin
                        r_owner  <= w_gnt_idx;
                        r_ptr    <= w_ptr_nxt;
                        r_lo     <= '0;
                        r_hi     <= '0;
                        r_err    <= 1'b0;
                        ALU_OP   <= REQ_OP[w_gnt_idx*4 +: 4];
                        ALU_MOVI <= REQ_MOVI[w_gnt_idx*2 +: 2];
                        ALU_A    <= REQ_A[w_gnt_idx*32 +: 32];
                        ALU_B    <= REQ_B[w_gnt_idx*32 +: 32];
                        ALU_MEM  <= REQ_MEM[w_gnt_idx*32 +: 32];
                        ALU_IMM  <= REQ_IMM[w_gnt_idx*32 +: 32];
                    end
                end
                S_ISSUE: r_cnt <= '0;
                S_BEAT_LO, S_BEAT_HI: begin
                    if (ALU_VLD) begin
                        if (r_state == S_BEAT_LO) r_lo <= ALU_DATA;
                        else                      r_hi <= ALU_DATA;
                        r_cnt <= '0;
                    end else if (w_timeout) begin
                        // A stalled ALU yields an error response with zero data.
                        r_err <= 1'b1;
                        r_lo  <= '0;
                        r_hi  <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign RSP_DATA = {r_hi, r_lo};
    assign RSP_ERR  = r_err;
    assign BUSY     = (r_state != S_IDLE);

endmodule
`default_nettype wire
